// File: rtl/sound_ctrl.sv
// sound_ctrl: turns CPU register writes into gated enables, timed launch strobes and a decaying crash level
module sound_ctrl #(
  parameter int LS_TICKS   = 48,
  parameter int CRSH_DECAY = 120,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_12KHz_en,
  input  logic       mod_redbaron,
  input  logic       cpu_wr,
  input  logic       cpu_addr,
  input  logic [7:0] cpu_data,
  output logic       sound_enable,
  output logic       motor_en,
  output logic       engine_rev_en,
  output logic       shell_en,
  output logic       shell_ls,
  output logic       explo_en,
  output logic       explo_ls,
  output logic [3:0] crsh,
  output logic [2:0] status
);
  typedef enum logic {IDLE, ACTIVE} os_t;
  os_t              os     [2];
  logic [CNT_W-1:0] os_cnt [2];
  logic [CNT_W-1:0] dcnt;
  logic [3:0]       level;
  logic             snd, ex_en, sh_en, mot, rev;
  logic             ctl_wr, crs_wr, snd_nx;
  logic             unused_bit;
  assign unused_bit = cpu_data[6];
  assign ctl_wr = cpu_wr & ~cpu_addr;
  assign crs_wr = cpu_wr & cpu_addr;
  // mute decisions use the enable value being written this cycle
  assign snd_nx = ctl_wr ? cpu_data[0] : snd;
  // index 0 = explosion (trigger bit1), index 1 = shell (trigger bit2)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {snd, ex_en, sh_en, mot, rev} <= '0;
      for (int i = 0; i < 2; i++) begin
        os[i]     <= IDLE;
        os_cnt[i] <= '0;
      end
      level <= '0;
      dcnt  <= '0;
    end else begin
      if (ctl_wr) {rev, mot, sh_en, ex_en, snd} <= {cpu_data[7], cpu_data[5], cpu_data[4], cpu_data[3], cpu_data[0]};
      for (int i = 0; i < 2; i++) begin
        if (!snd_nx) begin
          os[i]     <= IDLE;
          os_cnt[i] <= '0;
        end else if (ctl_wr && cpu_data[i+1] && LS_TICKS != 0) begin
          os[i]     <= ACTIVE;
          os_cnt[i] <= CNT_W'(LS_TICKS);
        end else if (os[i] == ACTIVE && clk_12KHz_en) begin
          os_cnt[i] <= os_cnt[i] - CNT_W'(1);
          if (os_cnt[i] == CNT_W'(1)) os[i] <= IDLE;
        end
      end
      if (!snd_nx) begin
        level <= '0;
        dcnt  <= '0;
      end else if (crs_wr) begin
        level <= cpu_data[3:0];
        dcnt  <= '0;
      end else if (level != 4'd0 && clk_12KHz_en) begin
        if (dcnt == CNT_W'(CRSH_DECAY - 1)) begin
          dcnt  <= '0;
          level <= level - 4'd1;
        end else begin
          dcnt <= dcnt + CNT_W'(1);
        end
      end
    end
  end
  assign sound_enable  = snd;
  assign motor_en      = mot & ~mod_redbaron;
  assign engine_rev_en = rev & ~mod_redbaron;
  assign shell_en      = sh_en;
  assign shell_ls      = os[1] == ACTIVE;
  assign explo_en      = ex_en & ~mod_redbaron;
  assign explo_ls      = (os[0] == ACTIVE) & ~mod_redbaron;
  assign crsh          = mod_redbaron ? level : 4'd0;
  assign status        = {crsh != 4'd0, shell_ls, explo_ls};
endmodule

// File: doc/sound_ctrl.md
Name: sound_ctrl

Overview:
- CPU-facing sequencer that drives the control inputs of the analog sound datapath from register writes.
- Inputs feeding that datapath: sound_enable, motor_en, engine_rev_en, shell_en/shell_ls, explo_en/explo_ls, crsh.
- Turns single CPU writes into timed one-shot launch strobes for shell/explosion noise and a stepwise-decaying crash level for Red Baron.
- Sits between the CPU address decoder and the analog sound mixer.
- Applies game-mode gating so only signals valid for the selected game reach the datapath.

Parameters:
- LS_TICKS, 48, length of shell_ls/explo_ls pulses in clk_12KHz_en ticks (48 ticks = 4 ms).
- CRSH_DECAY, 120, clk_12KHz_en ticks per one-step crsh decrement.
- CNT_W, 8, width of the one-shot and decay counters. LS_TICKS and CRSH_DECAY must each fit in CNT_W bits.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- clk_12KHz_en  in  1  one-cycle tick enable
- mod_redbaron  in  1  game select: 1 = Red Baron, 0 = Battle Zone
- cpu_wr  in  1  write strobe, one clk wide
- cpu_addr  in  1  register select: 0 = control, 1 = crash
- cpu_data  in  8  write data
- sound_enable  out  1  master sound enable
- motor_en  out  1  engine motor enable
- engine_rev_en  out  1  engine rev enable
- shell_en  out  1  shell noise enable
- shell_ls  out  1  shell launch strobe (timed)
- explo_en  out  1  explosion noise enable
- explo_ls  out  1  explosion launch strobe (timed)
- crsh  out  4  crash level
- status  out  3  {crsh!=0, shell_ls, explo_ls}

Behaviour:
- Reset: all outputs, registers and counters clear to 0 asynchronously. A reset mid-pulse or mid-decay aborts it immediately.
- Control write (cpu_wr, cpu_addr=0) takes effect on the next clock edge; outputs change 1 cycle after the write. Bit mapping:
  - bit0 sound_enable
  - bit1 explo_ls trigger
  - bit2 shell_ls trigger
  - bit3 explo_en
  - bit4 shell_en
  - bit5 motor_en
  - bit6 unused
  - bit7 engine_rev_en
- Bits 0, 3, 4, 5 and 7 are level-latched.
- Bits 1 and 2 are triggers and are not stored.
- One-shot FSM, one instance each for shell and explosion. States IDLE and ACTIVE.
  - Trigger with sound_enable (new value) = 1: load counter with LS_TICKS and go to ACTIVE.
  - ACTIVE: each clk_12KHz_en decrements the counter. On reaching 0, go to IDLE.
  - The *_ls output is registered; it is high iff the state is ACTIVE.
  - Retrigger while ACTIVE reloads the counter; the pulse is extended, not doubled.
  - Trigger and tick in the same cycle: the reload wins and that tick is ignored.
  - LS_TICKS = 0: a trigger never leaves IDLE.
- Crash write (cpu_wr, cpu_addr=1) loads level = cpu_data[3:0] and clears the decay counter.
  - While level != 0, each tick increments the decay counter. When it reaches CRSH_DECAY it resets to 0 and level decrements by 1. Level saturates at 0.
  - A write of 0 clears the level immediately.
  - A write and a tick in the same cycle: the write wins.
- Master mute: if sound_enable is 0 (after a write or after reset), both one-shots are forced to IDLE and the crash level is forced to 0. Triggers are ignored while it stays 0.
- Mode gating (combinational on the registered state):
  - mod_redbaron = 1: motor_en, engine_rev_en, explo_en and explo_ls are forced to 0.
  - mod_redbaron = 0: crsh is forced to 0.
  - Internal state keeps running regardless, so toggling mod_redbaron exposes the live state.
- A cpu_addr outside 0/1 is impossible (1-bit port). Writes without cpu_wr have no effect.

Test Plan:
- Reset: assert rst mid-simulation while explo_ls is active -> all outputs 0 immediately, and no pulse resumes after release.
- One-shot: write 0x03 (BZ mode), with default LS_TICKS=48 -> sound_enable=1 and explo_ls=1 one clk after the write; explo_ls falls on the 48th tick; shell_ls stays 0.
- Retrigger: write 0x05 starting shell_ls, then write 0x05 again after 30 ticks -> shell_ls stays high continuously and falls 48 ticks after the second write. Repeat with the second write coincident with a tick -> same result.
- Crash decay: Red Baron mode with sound_enable=1; write crash 0x3 -> crsh=3, then 2 after 120 ticks, 1 after 240, 0 after 360; status[2] goes 1 then 0. Write 0x0 mid-decay -> crsh=0 next cycle.
- Mute: while shell_ls is active and crsh=5, write control 0x00 -> shell_ls=0 and crsh=0 next cycle. A subsequent crash write of 0x7 while muted leaves crsh at 0.
- Mode gating: write 0xA9 (sound, explo_en, motor, rev) with mod_redbaron=0 -> motor_en=1, engine_rev_en=1, explo_en=1. Set mod_redbaron=1 -> all three read 0 in the same cycle. Set mod_redbaron=0 again -> all three read 1.
